lfsr_interval_gen: RTL and testbench
====================================

// Module: lfsr_interval_gen
// PURPOSE
//   Parametrised Fibonacci LFSR with a tick-driven countdown timer.
//   Produces pseudo-random intervals of MIN_INTERVAL..MIN_INTERVAL+2^OUT_BITS-1 ticks.
//   Emits a one-cycle spawn pulse when each interval expires.
//   Sits between the frame-tick generator and the obstacle spawner; supports runtime seeding.
// PARAMETERS
//   WIDTH        8      LFSR width in bits (3..16)
//   TAPS         8'hB8  feedback mask; bit i set => lfsr[i] enters the XOR (default maximal, period 255)
//   SEED         8'h01  reset/fallback state; must be nonzero
//   OUT_BITS     4      number of LFSR MSBs used as the random offset (1..WIDTH)
//   MIN_INTERVAL 15     base interval in ticks (>=1)
//   FREE_RUN     0      1: LFSR also steps on every clk while en=1; 0: steps only in ARM
//   localparam CNT_W = $clog2(MIN_INTERVAL + 2**OUT_BITS)
// PORTS
//   clk        in   1         system clock, rising edge
//   reset      in   1         asynchronous, active-high; clears all state
//   en         in   1         game running; low forces IDLE
//   tick       in   1         count strobe (one-cycle pulse per frame)
//   seed_load  in   1         load seed_in into the LFSR this cycle
//   seed_in    in   WIDTH     runtime seed
//   rnd        out  WIDTH     current LFSR state (registered)
//   interval   out  CNT_W     interval latched at the last ARM
//   count      out  CNT_W     ticks remaining in the current interval
//   spawn      out  1         one-cycle pulse when an interval expires
// BEHAVIOUR
//   Reset (async): rnd=SEED, state=IDLE, count=0, interval=0, spawn=0.
//   LFSR step:
//     f = ^(rnd & TAPS); next = {rnd[WIDTH-2:0], f}.
//   LFSR priority, highest first:
//     - seed_load: rnd <= seed_in, or SEED if seed_in==0 (all-zero lock-up never entered).
//     - step (ARM, or FREE_RUN && en).
//     - hold.
//   Random offset:
//     - off = rnd[WIDTH-1 -: OUT_BITS], taken from rnd BEFORE the same-cycle step.
//     - interval_next = MIN_INTERVAL + off, zero-extended to CNT_W; no overflow by CNT_W sizing.
//   FSM states: IDLE, ARM, COUNT.
//     IDLE:
//       - en=1 -> ARM.
//       - count holds 0; spawn=0.
//     ARM (exactly one cycle):
//       - interval <= interval_next; count <= interval_next.
//       - LFSR steps once (unless seed_load).
//       - -> COUNT.
//       - A tick arriving in ARM is ignored.
//     COUNT:
//       - tick && count>1: count decrements.
//       - tick && count==1: count <= 0, spawn <= 1 (visible next cycle), -> ARM.
//       - No tick: hold.
//   Spawn timing:
//     - spawn is registered. It is high for exactly the cycle after the Nth tick, which is the following ARM cycle.
//     - Spawns are never back-to-back, since interval >= 1 and ARM is one cycle.
//   en low in any state:
//     - Next cycle is IDLE with count=0 and spawn=0.
//     - A pending expiry on the same tick is discarded (en wins over tick).
//     - The LFSR keeps its value and seed_load still works.
//   seed_load during COUNT: the current count is unaffected; the new seed applies from the next ARM.
//   Reset mid-interval: immediate return to reset values; no spawn.
// TESTING
//   1. reset, then seed_load=0, en=0 -> rnd=8'h01, spawn=0, count=0.
//   2. FREE_RUN=1, en=1, seed 01 -> rnd sequence 01,02,04,08,11; returns to 01 after exactly 255 steps.
//   3. seed_load with seed_in=0 -> rnd=SEED(01); seed_in=8'hA5 -> rnd=A5 next cycle.
//   4. seed 01, en=1, tick every 4 clk:
//      - interval=15, spawn pulses 1 cycle after the 15th tick.
//      - next interval=15+rnd[7:4] of 8'h02 = 15.
//   5. seed 8'hF0, en=1 -> interval=30; drop en after 10 ticks -> IDLE, count=0, no spawn.
//   6. Assert reset mid-COUNT (count=7) -> rnd=01, count=0, spawn=0 in the same cycle.
//      Tick together with en=0 at count==1 -> no spawn.

Source files
------------

// File: rtl/lfsr_interval_gen.sv
// Fibonacci LFSR feeding a tick-driven countdown; emits a one-cycle spawn pulse
// each time a pseudo-random interval of MIN_INTERVAL..MIN_INTERVAL+2^OUT_BITS-1 ticks expires.
`timescale 1ns/1ps
module lfsr_interval_gen #(
  parameter int               WIDTH        = 8,
  parameter logic [WIDTH-1:0] TAPS         = 'hB8,
  parameter logic [WIDTH-1:0] SEED         = 'h01,
  parameter int               OUT_BITS     = 4,
  parameter int               MIN_INTERVAL = 15,
  parameter int               FREE_RUN     = 0,
  localparam int              CNT_W        = $clog2(MIN_INTERVAL + 2**OUT_BITS)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             tick,
  input  logic             seed_load,
  input  logic [WIDTH-1:0] seed_in,
  output logic [WIDTH-1:0] rnd,
  output logic [CNT_W-1:0] interval,
  output logic [CNT_W-1:0] count,
  output logic             spawn
);

  // state | meaning
  // IDLE  | stopped, count held at 0
  // ARM   | one cycle: latch new interval, step LFSR
  // COUNT | decrement on each tick until expiry
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ARM   = 2'd1;
  localparam logic [1:0] S_COUNT = 2'd2;

  logic [1:0]          state;
  logic                fb;
  logic [WIDTH-1:0]    rnd_step;
  logic [OUT_BITS-1:0] off;
  logic [CNT_W-1:0]    interval_next;
  logic                do_step;

  assign fb            = ^(rnd & TAPS);
  assign rnd_step      = {rnd[WIDTH-2:0], fb};
  assign off           = rnd[WIDTH-1 -: OUT_BITS];
  assign interval_next = CNT_W'(MIN_INTERVAL) + CNT_W'(off);
  assign do_step       = en && ((state == S_ARM) || (FREE_RUN != 0));

  // A zero seed would lock the LFSR, so it falls back to SEED.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rnd <= SEED;
    end else if (seed_load) begin
      rnd <= (seed_in == '0) ? SEED : seed_in;
    end else if (do_step) begin
      rnd <= rnd_step;
    end
  end

  // en low overrides everything, including an expiry on the same tick.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= S_IDLE;
      count    <= '0;
      interval <= '0;
      spawn    <= 1'b0;
    end else begin
      spawn <= 1'b0;
      if (!en) begin
        state <= S_IDLE;
        count <= '0;
      end else begin
        case (state)
          S_IDLE: begin
            count <= '0;
            state <= S_ARM;
          end
          S_ARM: begin
            interval <= interval_next;
            count    <= interval_next;
            state    <= S_COUNT;
          end
          S_COUNT: begin
            if (tick) begin
              if (count > CNT_W'(1)) begin
                count <= count - CNT_W'(1);
              end else begin
                count <= '0;
                spawn <= 1'b1;
                state <= S_ARM;
              end
            end
          end
          default: begin
            state <= S_IDLE;
            count <= '0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_lfsr_interval_gen.sv
// Directed bench for lfsr_interval_gen: spawn timing tracked via an expected-cycle queue,
// register values checked with immediate assertions after each step.
`timescale 1ns/1ps
module tb_lfsr_interval_gen;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       en = 1'b0, tick = 1'b0, seed_load = 1'b0;
  logic [7:0] seed_in = 8'h00;
  logic [7:0] rnd;
  logic [4:0] interval, count;
  logic       spawn;

  logic       fr_en = 1'b0, fr_tick = 1'b0, fr_seed_load = 1'b0;
  logic [7:0] fr_seed_in = 8'h00;
  logic [7:0] fr_rnd;
  logic [4:0] fr_interval, fr_count;
  logic       fr_spawn;

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;
  int exp_q[$];

  lfsr_interval_gen dut (
    .clk(clk), .reset(reset), .en(en), .tick(tick), .seed_load(seed_load),
    .seed_in(seed_in), .rnd(rnd), .interval(interval), .count(count), .spawn(spawn)
  );

  lfsr_interval_gen #(.FREE_RUN(1)) dut_fr (
    .clk(clk), .reset(reset), .en(fr_en), .tick(fr_tick), .seed_load(fr_seed_load),
    .seed_in(fr_seed_in), .rnd(fr_rnd), .interval(fr_interval), .count(fr_count),
    .spawn(fr_spawn)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Every spawn pulse must match the next expected cycle in the queue.
  always @(negedge clk) begin
    if (!reset && spawn === 1'b1) begin
      int e;
      n_vec++;
      e = (exp_q.size() > 0) ? exp_q.pop_front() : -1;
      assert (cyc === e) else begin
        n_err++;
        $error("FAIL spawn_cycle: observed %0d expected %0d", cyc, e);
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic tick1();
    tick = 1'b1;
    step(1);
    tick = 1'b0;
  endtask

  task automatic load_seed(input logic [7:0] s);
    seed_in   = s;
    seed_load = 1'b1;
    step(1);
    seed_load = 1'b0;
  endtask

  initial begin
    logic [7:0] fr_exp [4];
    int         steps;
    fr_exp = '{8'h02, 8'h04, 8'h08, 8'h11};

    // reset state
    step(2);
    chk("rst_rnd", rnd, 8'h01);
    chk("rst_count", count, 5'd0);
    chk("rst_interval", interval, 5'd0);
    chk("rst_spawn", spawn, 1'b0);
    @(negedge clk) reset = 1'b0;
    step(2);
    chk("idle_rnd", rnd, 8'h01);
    chk("idle_count", count, 5'd0);

    // seeding, including zero-seed fallback
    load_seed(8'h00);
    chk("seed_zero", rnd, 8'h01);
    load_seed(8'hA5);
    chk("seed_a5", rnd, 8'hA5);
    step(2);
    chk("seed_hold", rnd, 8'hA5);

    // free-running LFSR sequence and period
    fr_en = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step(1);
      chk($sformatf("fr_seq%0d", i), fr_rnd, fr_exp[i]);
    end
    steps = 4;
    while (fr_rnd !== 8'h01 && steps < 300) begin
      step(1);
      steps++;
    end
    chk("fr_period", steps, 255);
    fr_en = 1'b0;

    // seed 01, tick every 4 clocks
    load_seed(8'h01);
    en = 1'b1;
    step(1);
    chk("arm_count", count, 5'd0);
    step(1);
    chk("int15_interval", interval, 5'd15);
    chk("int15_count", count, 5'd15);
    chk("int15_rnd", rnd, 8'h02);
    for (int i = 0; i < 14; i++) begin
      tick1();
      step(3);
    end
    chk("int15_count1", count, 5'd1);
    exp_q.push_back(cyc + 1);
    tick1();
    chk("expire_count", count, 5'd0);
    chk("expire_spawn", spawn, 1'b1);
    tick1();  // lands in ARM and must be ignored
    chk("rearm_count", count, 5'd15);
    chk("rearm_interval", interval, 5'd15);
    chk("rearm_spawn", spawn, 1'b0);
    chk("rearm_rnd", rnd, 8'h04);

    // seed F0 gives the maximum interval; en drop abandons it
    en = 1'b0;
    step(1);
    chk("en_low_count", count, 5'd0);
    load_seed(8'hF0);
    en = 1'b1;
    step(2);
    chk("int30_interval", interval, 5'd30);
    chk("int30_count", count, 5'd30);
    chk("int30_rnd", rnd, 8'hE1);
    for (int i = 0; i < 10; i++) begin
      tick1();
      step(3);
    end
    chk("int30_after10", count, 5'd20);
    seed_in   = 8'hA5;
    seed_load = 1'b1;
    tick      = 1'b1;
    step(1);
    seed_load = 1'b0;
    tick      = 1'b0;
    chk("seed_mid_count", count, 5'd19);
    chk("seed_mid_rnd", rnd, 8'hA5);
    chk("seed_mid_interval", interval, 5'd30);
    en   = 1'b0;
    tick = 1'b1;
    step(1);
    tick = 1'b0;
    chk("drop_count", count, 5'd0);
    chk("drop_spawn", spawn, 1'b0);
    step(2);
    chk("drop_rnd_hold", rnd, 8'hA5);

    // async reset mid-interval
    load_seed(8'h01);
    en = 1'b1;
    step(2);
    for (int i = 0; i < 8; i++) begin
      tick1();
      step(3);
    end
    chk("pre_rst_count", count, 5'd7);
    #2 reset = 1'b1;
    #1;
    chk("mid_rst_rnd", rnd, 8'h01);
    chk("mid_rst_count", count, 5'd0);
    chk("mid_rst_spawn", spawn, 1'b0);
    chk("mid_rst_interval", interval, 5'd0);
    en = 1'b0;
    @(negedge clk) reset = 1'b0;
    step(1);

    // expiry tick coinciding with en low is discarded
    en = 1'b1;
    step(2);
    chk("last_count", count, 5'd15);
    for (int i = 0; i < 14; i++) begin
      tick1();
      step(3);
    end
    chk("last_count1", count, 5'd1);
    en   = 1'b0;
    tick = 1'b1;
    step(1);
    tick = 1'b0;
    chk("en_wins_count", count, 5'd0);
    chk("en_wins_spawn", spawn, 1'b0);
    step(3);
    chk("spawn_q_empty", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
